// File: rtl/cpu_pkg.sv
// Shared opcode constants, stage record and opcode-class helpers
// for the instruction pipeline control path.
package cpu_pkg;

    localparam int OPW  = 5;
    localparam int RW   = 3;
    localparam int CNTW = 16;

    localparam logic [OPW-1:0] OP_MV   = 5'b00000;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00001;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00010;
    localparam logic [OPW-1:0] OP_CMP  = 5'b00011;
    localparam logic [OPW-1:0] OP_LD   = 5'b00100;
    localparam logic [OPW-1:0] OP_ST   = 5'b00101;
    localparam logic [OPW-1:0] OP_MVI  = 5'b10000;
    localparam logic [OPW-1:0] OP_MVHI = 5'b10110;
    localparam logic [OPW-1:0] NOP_OP  = 5'b01111;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [RW-1:0]  rx;
        logic [RW-1:0]  ry;
        logic           valid;
    } stage_t;

    localparam stage_t BUBBLE = '{
        op:    NOP_OP,
        rx:    '0,
        ry:    '0,
        valid: 1'b0
    };

    function automatic logic writes(input logic [OPW-1:0] op);
        return !op[3] && !(op[1] && op[0]);
    endfunction

    function automatic logic uses_rx(input logic [OPW-1:0] op);
        return !(op == OP_MV || op == OP_MVI || op == OP_LD)
            && !(op[3] && op[4]);
    endfunction

    function automatic logic uses_ry(input logic [OPW-1:0] op);
        return !op[4] && !op[3];
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// RAW hazard detection: the RegRead instruction waits while an older
// instruction in Execute or Writeback still has to write a source register.
module hazard_unit
    import cpu_pkg::*;
(
    input  stage_t s2,
    input  stage_t s3,
    input  stage_t s4,
    output logic   stall
);

    function automatic logic hit(input stage_t cur, input stage_t old);
        return old.valid && writes(old.op)
            && ((uses_rx(cur.op) && old.rx == cur.rx)
             || (uses_ry(cur.op) && old.rx == cur.ry));
    endfunction

    assign stall = s2.valid && (hit(s2, s3) || hit(s2, s4));

endmodule

// File: rtl/opcode_pipeline.sv
// Four-stage opcode/register-field pipeline with RAW stall, branch
// bubbling, fetch hold and saturating stall/bubble counters.
module opcode_pipeline
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    input  logic             br_resolved,
    output logic [OPW-1:0]   opcode [1:4],
    output logic [RW-1:0]    rx_rd,
    output logic [RW-1:0]    ry_rd,
    output logic [RW-1:0]    rx_wb,
    output logic             fetch_ready,
    output logic             stall,
    output logic [CNTW-1:0]  stall_cnt,
    output logic [CNTW-1:0]  bubble_cnt
);

    stage_t s1, s2, s3, s4;
    stage_t fetched;
    logic   br_pending;
    logic   take;
    logic   br_enter;
    logic   bubble_in;
    logic   unused_hi;

    hazard_unit u_hazard (
        .s2    (s2),
        .s3    (s3),
        .s4    (s4),
        .stall (stall)
    );

    assign fetched = '{
        op:    instr[OPW-1:0],
        rx:    instr[OPW+RW-1:OPW],
        ry:    instr[OPW+2*RW-1:OPW+RW],
        valid: 1'b1
    };
    assign unused_hi = ^instr[15:OPW+2*RW];

    assign fetch_ready = !br_pending && !stall;
    assign take        = instr_valid && fetch_ready;
    // a branch leaving Fetch closes the front end until Execute resolves it
    assign br_enter    = s1.valid && s1.op[3] && !stall;
    assign bubble_in   = stall || !s2.valid;

    assign opcode[1] = s1.valid ? s1.op : NOP_OP;
    assign opcode[2] = s2.valid ? s2.op : NOP_OP;
    assign opcode[3] = s3.valid ? s3.op : NOP_OP;
    assign opcode[4] = s4.valid ? s4.op : NOP_OP;

    assign rx_rd = s2.rx;
    assign ry_rd = s2.ry;
    assign rx_wb = s4.rx;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= BUBBLE;
            s2         <= BUBBLE;
            s3         <= BUBBLE;
            s4         <= BUBBLE;
            br_pending <= 1'b0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            s4 <= s3;
            if (stall) begin
                s3 <= BUBBLE;
            end else begin
                s3 <= s2;
                s2 <= s1;
                s1 <= take ? fetched : BUBBLE;
            end
            if (br_enter) begin
                br_pending <= 1'b1;
            end else if (br_resolved) begin
                br_pending <= 1'b0;
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bubble_in && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opcode_pipeline.sv
// Cycle tables for hazards, branches and resets, then a random
// dependency-heavy stream checked in order at Writeback.
module tb_opcode_pipeline;

    localparam logic [4:0] N   = 5'b01111;
    localparam logic [4:0] ADD = 5'b00001;
    localparam logic [4:0] SUB = 5'b00010;
    localparam logic [4:0] ST  = 5'b00101;
    localparam logic [4:0] LD  = 5'b00100;
    localparam logic [4:0] MVI = 5'b10000;
    localparam logic [4:0] JZ  = 5'b01001;
    localparam logic [15:0] NONE = 16'h0000;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] ins;
        logic        br;
        logic [4:0]  e1, e2, e3, e4;
        logic        est, efr;
        logic [15:0] esc, ebc;
        logic [2:0]  erx, ery;
    } vec_t;

    typedef struct packed {
        logic [4:0] op;
        logic [2:0] rx;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        br_resolved;
    logic [4:0]  opcode [1:4];
    logic [2:0]  rx_rd, ry_rd, rx_wb;
    logic        fetch_ready;
    logic        stall;
    logic [15:0] stall_cnt, bubble_cnt;

    int   total = 0;
    int   bad   = 0;
    int   row   = 0;
    vec_t tbl[$];
    sb_t  sbq[$];
    logic [4:0] rops [8];

    opcode_pipeline dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .br_resolved (br_resolved),
        .opcode      (opcode),
        .rx_rd       (rx_rd),
        .ry_rd       (ry_rd),
        .rx_wb       (rx_wb),
        .fetch_ready (fetch_ready),
        .stall       (stall),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mk(input logic [4:0] op, input int rx,
                                       input int ry);
        return {5'b0, 3'(ry), 3'(rx), op};
    endfunction

    function automatic vec_t r(
        input int rst, input int iv, input logic [15:0] ins, input int br,
        input logic [4:0] e1, input logic [4:0] e2,
        input logic [4:0] e3, input logic [4:0] e4,
        input int est, input int efr, input int esc, input int ebc,
        input int erx, input int ery);
        vec_t v;
        v.rst = 1'(rst);
        v.iv  = 1'(iv);
        v.ins = ins;
        v.br  = 1'(br);
        v.e1  = e1;
        v.e2  = e2;
        v.e3  = e3;
        v.e4  = e4;
        v.est = 1'(est);
        v.efr = 1'(efr);
        v.esc = 16'(esc);
        v.ebc = 16'(ebc);
        v.erx = 3'(erx);
        v.ery = 3'(ery);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
        end
    endtask

    task automatic sb_check();
        sb_t e;
        if (opcode[4] !== N) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow row=%0d got=%0h want=none",
                         row, opcode[4]);
            end else begin
                e = sbq.pop_front();
                check("wb_op", 32'(opcode[4]), 32'(e.op));
                check("rx_wb", 32'(rx_wb), 32'(e.rx));
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        br_resolved = 1'b0;
        #1;
        sb_check();
        @(posedge clk);
    endtask

    initial begin
        vec_t       v;
        logic [4:0] op;
        int         rx, ry;
        bit         acc;

        rops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                 5'b00100, 5'b00101, 5'b10000, 5'b10110};

        // independent stream
        tbl.push_back(r(0,1,mk(ADD,1,2),0, N,N,N,N,     0,1,0,0,0,0));
        tbl.push_back(r(0,1,mk(SUB,3,4),0, ADD,N,N,N,   0,1,0,1,0,0));
        tbl.push_back(r(0,1,mk(ST,5,6),0,  SUB,ADD,N,N, 0,1,0,2,1,2));
        tbl.push_back(r(0,0,NONE,0,        ST,SUB,ADD,N,0,1,0,2,3,4));
        tbl.push_back(r(0,0,NONE,0,        N,ST,SUB,ADD,0,1,0,2,5,6));
        tbl.push_back(r(0,0,NONE,0,        N,N,ST,SUB,  0,1,0,2,0,0));
        tbl.push_back(r(0,0,NONE,0,        N,N,N,ST,    0,1,0,3,0,0));
        // RAW on ry through Execute then Writeback
        tbl.push_back(r(1,0,NONE,0,        N,N,N,N,     0,1,0,4,0,0));
        tbl.push_back(r(0,1,mk(ADD,1,2),0, N,N,N,N,     0,1,0,0,0,0));
        tbl.push_back(r(0,1,mk(SUB,3,1),0, ADD,N,N,N,   0,1,0,1,0,0));
        tbl.push_back(r(0,0,NONE,0,        SUB,ADD,N,N, 0,1,0,2,1,2));
        tbl.push_back(r(0,0,NONE,0,        N,SUB,ADD,N, 1,0,0,2,3,1));
        tbl.push_back(r(0,0,NONE,0,        N,SUB,N,ADD, 1,0,1,3,3,1));
        tbl.push_back(r(0,0,NONE,0,        N,SUB,N,N,   0,1,2,4,3,1));
        tbl.push_back(r(0,0,NONE,0,        N,N,SUB,N,   0,1,2,4,0,0));
        tbl.push_back(r(0,0,NONE,0,        N,N,N,SUB,   0,1,2,5,0,0));
        // ld then mvi, stray br_resolved ignored
        tbl.push_back(r(1,0,NONE,0,        N,N,N,N,     0,1,2,6,0,0));
        tbl.push_back(r(0,1,mk(LD,2,3),0,  N,N,N,N,     0,1,0,0,0,0));
        tbl.push_back(r(0,1,mk(MVI,2,0),1, LD,N,N,N,    0,1,0,1,0,0));
        tbl.push_back(r(0,0,NONE,0,        MVI,LD,N,N,  0,1,0,2,2,3));
        tbl.push_back(r(0,0,NONE,0,        N,MVI,LD,N,  0,1,0,2,2,0));
        tbl.push_back(r(0,0,NONE,0,        N,N,MVI,LD,  0,1,0,2,0,0));
        // branch: delay slot accepted, next fetch dropped
        tbl.push_back(r(1,0,NONE,0,        N,N,N,MVI,   0,1,0,3,0,0));
        tbl.push_back(r(0,1,mk(JZ,1,0),0,  N,N,N,N,     0,1,0,0,0,0));
        tbl.push_back(r(0,1,mk(ADD,4,5),0, JZ,N,N,N,    0,1,0,1,0,0));
        tbl.push_back(r(0,1,mk(SUB,6,7),0, ADD,JZ,N,N,  0,0,0,2,1,0));
        tbl.push_back(r(0,0,NONE,1,        N,ADD,JZ,N,  0,0,0,2,4,5));
        tbl.push_back(r(0,1,mk(ADD,1,2),0, N,N,ADD,JZ,  0,1,0,2,0,0));
        tbl.push_back(r(0,0,NONE,0,        ADD,N,N,ADD, 0,1,0,3,0,0));
        // branch stalled in RegRead while it resolves
        tbl.push_back(r(1,0,NONE,0,        N,ADD,N,N,   0,1,0,4,1,2));
        tbl.push_back(r(0,1,mk(ADD,1,2),0, N,N,N,N,     0,1,0,0,0,0));
        tbl.push_back(r(0,1,mk(JZ,1,0),0,  ADD,N,N,N,   0,1,0,1,0,0));
        tbl.push_back(r(0,1,mk(SUB,3,4),0, JZ,ADD,N,N,  0,1,0,2,1,2));
        tbl.push_back(r(0,0,NONE,1,        SUB,JZ,ADD,N,1,0,0,2,1,0));
        tbl.push_back(r(0,0,NONE,0,        SUB,JZ,N,ADD,1,0,1,3,1,0));
        tbl.push_back(r(0,1,mk(ADD,7,7),0, SUB,JZ,N,N,  0,1,2,4,1,0));
        tbl.push_back(r(0,0,NONE,0,        ADD,SUB,JZ,N,0,1,2,4,3,4));
        tbl.push_back(r(0,0,NONE,0,        N,ADD,SUB,JZ,0,1,2,4,7,7));
        // reset while a stall is active
        tbl.push_back(r(0,1,mk(ADD,2,3),0, N,N,ADD,SUB, 0,1,2,4,0,0));
        tbl.push_back(r(0,1,mk(LD,4,2),0,  ADD,N,N,ADD, 0,1,2,5,0,0));
        tbl.push_back(r(0,0,NONE,0,        LD,ADD,N,N,  0,1,2,6,2,3));
        tbl.push_back(r(1,0,NONE,0,        N,LD,ADD,N,  1,0,2,6,4,2));
        tbl.push_back(r(0,0,NONE,0,        N,N,N,N,     0,1,0,0,0,0));

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = NONE;
        br_resolved = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            v   = tbl[i];
            row = i;
            @(negedge clk);
            reset       = v.rst;
            instr_valid = v.iv;
            instr       = v.ins;
            br_resolved = v.br;
            #1;
            check("op1",    32'(opcode[1]),  32'(v.e1));
            check("op2",    32'(opcode[2]),  32'(v.e2));
            check("op3",    32'(opcode[3]),  32'(v.e3));
            check("op4",    32'(opcode[4]),  32'(v.e4));
            check("stall",  32'(stall),      32'(v.est));
            check("fready", 32'(fetch_ready),32'(v.efr));
            check("scnt",   32'(stall_cnt),  32'(v.esc));
            check("bcnt",   32'(bubble_cnt), 32'(v.ebc));
            check("rx_rd",  32'(rx_rd),      32'(v.erx));
            check("ry_rd",  32'(ry_rd),      32'(v.ery));
            sb_check();
            if (!v.rst && v.iv && v.efr)
                sbq.push_back('{v.ins[4:0], v.ins[7:5]});
            @(posedge clk);
            if (v.rst)
                sbq.delete();
        end

        row = 1000;
        @(negedge clk);
        reset       = 1'b1;
        instr_valid = 1'b0;
        br_resolved = 1'b0;
        @(posedge clk);
        sbq.delete();

        for (int k = 0; k < 40; k++) begin
            op = rops[$urandom_range(0, 7)];
            rx = $urandom_range(0, 3);
            ry = $urandom_range(0, 3);
            sbq.push_back('{op, 3'(rx)});
            acc = 1'b0;
            for (int w = 0; w < 8 && !acc; w++) begin
                @(negedge clk);
                reset       = 1'b0;
                instr_valid = 1'b1;
                instr       = mk(op, rx, ry);
                #1;
                sb_check();
                acc = fetch_ready;
                @(posedge clk);
            end
            check("accept", 32'(acc), 32'd1);
            repeat ($urandom_range(0, 1)) idle();
        end
        for (int w = 0; w < 12 && sbq.size() != 0; w++)
            idle();
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
